// File: rtl/cmd_line_assembler.sv
// Line assembler: folds a stream of ASCII bytes into a left-justified,
// pad-filled command word with backspace, escape and overflow handling.
module cmd_line_assembler #(
   parameter int           NUM_CHARS = 5,
   parameter logic [7:0]   PAD_CHAR  = 8'h20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [8*NUM_CHARS-1:0] command,
   output logic                   cmd_valid,
   output logic                   cmd_error,
   output logic [2:0]             char_count,
   output logic [7:0]             echo_data,
   output logic                   echo_valid
);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, OVERFLOW} state_t;

   state_t state, state_n;
   logic [7:0] slots [NUM_CHARS];
   logic [7:0] slots_n [NUM_CHARS];
   logic [2:0] count_n;
   logic [8*NUM_CHARS-1:0] packed_line, command_n;
   logic cmd_valid_n, cmd_error_n, echo_valid_n, clear_line;
   logic [7:0] echo_data_n, folded;
   logic is_enter, is_bksp, is_esc, is_print, is_upper;

   assign is_enter = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   assign is_bksp  = (rx_data == 8'h08) || (rx_data == 8'h7F);
   assign is_esc   = (rx_data == 8'h1B);
   assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
   assign is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
   assign folded   = is_upper ? (rx_data | 8'h20) : rx_data;

   always_comb begin
      packed_line = '0;
      for (int i = 0; i < NUM_CHARS; i++)
         packed_line[8*(NUM_CHARS-1-i) +: 8] = slots[i];
   end

   always_comb begin
      state_n      = state;
      slots_n      = slots;
      count_n      = char_count;
      command_n    = command;
      cmd_valid_n  = 1'b0;
      cmd_error_n  = 1'b0;
      echo_valid_n = 1'b0;
      echo_data_n  = echo_data;
      clear_line   = 1'b0;
      if (rx_valid) begin
         unique case (state)
            EMPTY, FILLING: begin
               if (is_print) begin
                  slots_n[char_count] = folded;
                  count_n      = 3'(char_count + 3'd1);
                  state_n      = (count_n == 3'(NUM_CHARS)) ? FULL : FILLING;
                  echo_valid_n = 1'b1;
                  echo_data_n  = folded;
               end else if (is_enter) begin
                  echo_valid_n = 1'b1;
                  echo_data_n  = 8'h0D;
                  if (state == FILLING) begin
                     command_n   = packed_line;
                     cmd_valid_n = 1'b1;
                     clear_line  = 1'b1;
                  end
               end else if (is_bksp && state == FILLING) begin
                  slots_n[3'(char_count - 3'd1)] = PAD_CHAR;
                  count_n      = 3'(char_count - 3'd1);
                  state_n      = (char_count == 3'd1) ? EMPTY : FILLING;
                  echo_valid_n = 1'b1;
                  echo_data_n  = 8'h08;
               end else if (is_esc) begin
                  clear_line = 1'b1;
               end
            end
            FULL: begin
               if (is_print) begin
                  state_n = OVERFLOW;
               end else if (is_bksp) begin
                  slots_n[3'(char_count - 3'd1)] = PAD_CHAR;
                  count_n      = 3'(char_count - 3'd1);
                  state_n      = (char_count == 3'd1) ? EMPTY : FILLING;
                  echo_valid_n = 1'b1;
                  echo_data_n  = 8'h08;
               end else if (is_enter) begin
                  command_n    = packed_line;
                  cmd_valid_n  = 1'b1;
                  clear_line   = 1'b1;
                  echo_valid_n = 1'b1;
                  echo_data_n  = 8'h0D;
               end else if (is_esc) begin
                  clear_line = 1'b1;
               end
            end
            OVERFLOW: begin
               if (is_enter) begin
                  cmd_error_n  = 1'b1;
                  clear_line   = 1'b1;
                  echo_valid_n = 1'b1;
                  echo_data_n  = 8'h0D;
               end else if (is_esc) begin
                  clear_line = 1'b1;
               end
            end
            default: clear_line = 1'b1;
         endcase
      end
      if (clear_line) begin
         for (int i = 0; i < NUM_CHARS; i++)
            slots_n[i] = PAD_CHAR;
         count_n = 3'd0;
         state_n = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         for (int i = 0; i < NUM_CHARS; i++)
            slots[i] <= PAD_CHAR;
         char_count <= 3'd0;
         command    <= {NUM_CHARS{PAD_CHAR}};
         cmd_valid  <= 1'b0;
         cmd_error  <= 1'b0;
         echo_valid <= 1'b0;
         echo_data  <= 8'h00;
      end else begin
         state      <= state_n;
         slots      <= slots_n;
         char_count <= count_n;
         command    <= command_n;
         cmd_valid  <= cmd_valid_n;
         cmd_error  <= cmd_error_n;
         echo_valid <= echo_valid_n;
         echo_data  <= echo_data_n;
      end
   end

endmodule

// File: tb/tb_cmd_line_assembler.sv
// Bench for cmd_line_assembler: directed scenarios plus random bytes,
// checked each cycle against a queue-based model of the edited line.
module tb_cmd_line_assembler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [39:0] command;
   logic        cmd_valid, cmd_error, echo_valid;
   logic [2:0]  char_count;
   logic [7:0]  echo_data;

   int vectors = 0;
   int errors = 0;

   logic [7:0]  line_q [$];
   bit          ovf;
   logic [39:0] exp_cmd;
   logic        exp_cv, exp_ce, exp_ev;
   logic [7:0]  exp_ed;
   int          cv_seen;

   always #5 clk = ~clk;

   cmd_line_assembler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .command    (command),
      .cmd_valid  (cmd_valid),
      .cmd_error  (cmd_error),
      .char_count (char_count),
      .echo_data  (echo_data),
      .echo_valid (echo_valid)
   );

   task automatic chk(input string tag, input logic [39:0] got,
                      input logic [39:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] pack_line();
      logic [39:0] r = {5{8'h20}};
      for (int i = 0; i < line_q.size(); i++)
         r[8*(4-i) +: 8] = line_q[i];
      return r;
   endfunction

   task automatic model_reset();
      line_q.delete();
      ovf = 0;
      exp_cmd = {5{8'h20}};
      exp_cv = 0; exp_ce = 0; exp_ev = 0; exp_ed = 8'h00;
   endtask

   task automatic model_step(input logic v, input logic [7:0] b);
      logic [7:0] f;
      exp_cv = 0; exp_ce = 0; exp_ev = 0;
      if (!v) return;
      if (b == 8'h0D || b == 8'h0A) begin
         exp_ev = 1; exp_ed = 8'h0D;
         if (ovf) exp_ce = 1;
         else if (line_q.size() > 0) begin
            exp_cmd = pack_line();
            exp_cv = 1;
         end
         line_q.delete(); ovf = 0;
      end else if (b == 8'h08 || b == 8'h7F) begin
         if (!ovf && line_q.size() > 0) begin
            void'(line_q.pop_back());
            exp_ev = 1; exp_ed = 8'h08;
         end
      end else if (b == 8'h1B) begin
         line_q.delete(); ovf = 0;
      end else if (b >= 8'h20 && b <= 8'h7E) begin
         f = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
         if (!ovf) begin
            if (line_q.size() == 5) ovf = 1;
            else begin
               line_q.push_back(f);
               exp_ev = 1; exp_ed = f;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("command", command, exp_cmd);
      chk("cmd_valid", {39'd0, cmd_valid}, {39'd0, exp_cv});
      chk("cmd_error", {39'd0, cmd_error}, {39'd0, exp_ce});
      chk("char_count", {37'd0, char_count}, 40'(line_q.size()));
      chk("echo_valid", {39'd0, echo_valid}, {39'd0, exp_ev});
      if (exp_ev) chk("echo_data", {32'd0, echo_data}, {32'd0, exp_ed});
      if (cmd_valid) cv_seen++;
   endtask

   task automatic cycle(input logic v, input logic [7:0] b);
      @(negedge clk);
      check_outputs();
      rx_valid = v;
      rx_data  = b;
      model_step(v, b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 0;
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("rst_command", command, {5{8'h20}});
      chk("rst_count", {37'd0, char_count}, 40'd0);
      chk("rst_pulses", {37'd0, cmd_valid, cmd_error, echo_valid}, 40'd0);
      chk("rst_echo_data", {32'd0, echo_data}, 40'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   function automatic logic [7:0] rand_byte();
      int sel = $urandom_range(0, 19);
      if (sel < 8) return 8'($urandom_range(8'h61, 8'h7A));
      if (sel < 10) return 8'($urandom_range(8'h41, 8'h5A));
      if (sel < 12) return 8'($urandom_range(8'h20, 8'h40));
      if (sel == 12) return 8'h0D;
      if (sel == 13) return 8'h0A;
      if (sel == 14) return 8'h08;
      if (sel == 15) return 8'h7F;
      if (sel == 16) return 8'h1B;
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      model_reset();
      cv_seen = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      do_reset();

      send_str("reset"); cycle(1, 8'h0D);
      cycle(0, 0);
      chk("t1_cmd", command, 40'h7265736574);

      cv_seen = 0;
      send_str("03+05"); cycle(1, 8'h0D);
      repeat (100) cycle(0, 0);
      chk("t2_cmd", command, 40'h30332B3035);
      chk("t2_pulses", 40'(cv_seen), 40'd1);

      send_str("SMx"); cycle(1, 8'h08); send_str("ILE"); cycle(1, 8'h0D);
      cycle(0, 0);
      chk("t3_cmd", command, 40'h736D696C65);

      send_str("ab"); cycle(1, 8'h0D); cycle(1, 8'h0D);
      cycle(0, 0);
      chk("t4_cmd", command, 40'h6162202020);

      send_str("abcdef"); cycle(1, 8'h0D);
      cycle(0, 0);
      chk("t5_keep", command, 40'h6162202020);
      send_str("lazer"); cycle(1, 8'h0A);
      cycle(0, 0);
      chk("t5_cmd", command, 40'h6C617A6572);

      send_str("ab");
      do_reset();
      send_str("xy"); cycle(1, 8'h1B); cycle(0, 0);
      send_str("abcde"); cycle(1, 8'h7F); cycle(1, 8'h0D);
      send_str("abcdefg"); cycle(1, 8'h1B); cycle(1, 8'h0D);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) cycle(0, 0);
         else cycle(1, rand_byte());
         if (n % 1000 == 999) do_reset();
      end
      cycle(0, 0);
      cycle(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cmd_line_assembler.md
Name: cmd_line_assembler

Overview:
- Sits directly upstream of the command-decode/logic block.
- Collects a stream of ASCII bytes (e.g. from the UART receiver) into a fixed-width, left-justified, space-padded command word.
- Presents that word on the 40-bit command bus, where the first typed character occupies bits [39:32].
- Handles line editing (backspace, escape), case folding and overflow, so that downstream decode only ever sees complete, clean commands.

Parameters:
- NUM_CHARS, 5, number of characters per command; command width = 8*NUM_CHARS.
- PAD_CHAR, 8'h20, fill byte for unused trailing positions.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  single-cycle strobe; rx_data is valid when high.
- command  output  8*NUM_CHARS  last committed command; first char in MSBs.
- cmd_valid  output  1  one-cycle pulse when command is updated.
- cmd_error  output  1  one-cycle pulse when an overflowed line is discarded.
- char_count  output  3  characters currently buffered (0..NUM_CHARS).
- echo_data  output  8  byte to echo back to the terminal.
- echo_valid  output  1  one-cycle pulse qualifying echo_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - command = all PAD_CHAR.
  - cmd_valid = 0, cmd_error = 0, echo_valid = 0, echo_data = 0.
  - char_count = 0; line buffer cleared to PAD_CHAR; state = EMPTY.
  - Reset asserted mid-line discards the partial line with no pulse.
- Byte classes, checked on each cycle with rx_valid = 1; exactly one byte is accepted per strobe, with no back-pressure:
  - ENTER: 8'h0D or 8'h0A.
  - BKSP: 8'h08 or 8'h7F.
  - ESC: 8'h1B.
  - PRINT: 8'h20..8'h7E.
  - Any other byte is ignored, with no echo.
- Case folding: PRINT bytes 8'h41..8'h5A have bit 5 set before storage and echo ('A' becomes 'a').
- State machine:
  - EMPTY (count = 0):
    - PRINT → store at slot 0, count = 1, go to FILLING.
    - ENTER → no commit, no pulse; echo 8'h0D.
    - BKSP or ESC → ignored.
  - FILLING (0 < count < NUM_CHARS):
    - PRINT → store at slot[count], count+1; go to FULL when count reaches NUM_CHARS.
    - BKSP → slot[count-1] = PAD_CHAR, count-1; go to EMPTY at 0.
    - ENTER → commit.
    - ESC → clear the buffer, go to EMPTY.
  - FULL (count = NUM_CHARS):
    - PRINT → go to OVERFLOW; no store, no echo.
    - BKSP → as in FILLING.
    - ENTER → commit.
    - ESC → clear, go to EMPTY.
  - OVERFLOW:
    - PRINT or BKSP → ignored.
    - ENTER → clear the buffer; cmd_error pulses the next cycle; command unchanged; go to EMPTY.
    - ESC → clear, go to EMPTY, no error pulse.
- Commit:
  - The cycle after the ENTER strobe, command = buffer contents (unused slots hold PAD_CHAR) and cmd_valid = 1 for exactly one cycle.
  - In the same edge, the buffer is cleared, count = 0, state = EMPTY.
  - command then holds its value until the next commit or reset.
- Echo:
  - echo_valid pulses the cycle after each accepted PRINT, carrying the folded byte.
  - BKSP echoes 8'h08.
  - ENTER echoes 8'h0D.
  - ESC and ignored bytes produce no echo.
- Latency: every output is a register; the response appears exactly 1 cycle after the rx_valid strobe.
- Back-to-back strobes on consecutive cycles must be handled; a byte arriving in the cycle cmd_valid is high goes into the freshly cleared buffer.
- char_count always equals the number of non-pad slots written.

Test Plan:
1. Reset, then strobe "r","e","s","e","t",8'h0D → one cycle after ENTER: command = 40'h7265736574, cmd_valid high for 1 cycle, char_count = 0.
2. Strobe "0","3","+","0","5",ENTER, then wait 100 cycles → command = 40'h30332B3035 and holds; cmd_valid is pulsed exactly once.
3. Strobe "S","M","x",8'h08,"I","L","E",ENTER → command = 40'h736D696C65; echo sequence 73,6D,78,08,69,6C,65,0D.
4. Strobe "a","b",ENTER → command = 40'h6162202020. Then ENTER on an empty line → no cmd_valid, command unchanged.
5. Strobe six chars "abcdef",ENTER → cmd_error pulses once, cmd_valid stays 0, command retains its previous value. Then strobe "lazer",ENTER → command = 40'h6C617A6572.
6. Strobe "ab", assert rst_n low asynchronously between clock edges → command = 40'h2020202020, char_count = 0 immediately. Strobe ESC mid-line → buffer cleared, no pulses.
